// File: rtl/proj_step.sv
// proj_step: projectile trajectory stepper for a 32x32 playfield.
// Latches launcher column and aim slope on fire. On each tick it advances the
// projectile one cell along an integer Bresenham line. It reports the live cell
// and emits a one-cycle termination pulse that carries a reason code.
// Optional feature macro: PROJ_WRAP_EN. When it is defined, side-edge crossings
// wrap the column modulo 32 instead of terminating the flight.
module proj_step #(
    parameter int MAX_STEPS = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic       tick,
    input  logic [4:0] x_pos,
    input  logic [4:0] run,
    input  logic [4:0] rise,
    input  logic       dir,
    output logic [4:0] proj_x,
    output logic [4:0] proj_y,
    output logic       active,
    output logic       done,
    output logic [1:0] done_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] STEP_LIMIT = MAX_STEPS[5:0];
    localparam logic [1:0] CODE_TOP   = 2'b01;
    localparam logic [1:0] CODE_SIDE  = 2'b10;
    localparam logic [1:0] CODE_LIMIT = 2'b11;

    state_t     state_q, state_d;
    logic [4:0] x_q, x_d, y_q, y_d;
    logic [4:0] maj_q, maj_d, min_q, min_d;
    logic [5:0] err_q, err_d, cnt_q, cnt_d;
    logic       steep_q, steep_d, dir_q, dir_d;
    logic [1:0] code_q, code_d;

    // Launch-time slope decode
    logic [4:0] rise_eff;
    logic       launch_steep;
    logic [4:0] launch_maj, launch_min;

    // Per-step candidate computation
    logic [5:0] err_sum;
    logic       minor_step, x_step, y_step;
    logic [5:0] x_cand, y_cand;
    logic [5:0] cnt_inc;
    logic       hit_top, hit_side;

    // Slope decode and Bresenham candidate for the next step
    always_comb begin
        rise_eff     = (run == 5'd0 && rise == 5'd0) ? 5'd1 : rise;
        launch_steep = (rise_eff >= run);
        launch_maj   = launch_steep ? rise_eff : run;
        launch_min   = launch_steep ? run : rise_eff;

        // err < major <= 31 and minor <= 31, so the sum fits in 6 bits
        err_sum    = err_q + {1'b0, min_q};
        minor_step = (err_sum >= {1'b0, maj_q});
        x_step     = steep_q ? minor_step : 1'b1;
        y_step     = steep_q ? 1'b1 : minor_step;

        // Bit 5 of a candidate flags leaving the 0..31 range; bits 4:0 hold the
        // mod-32 column, which is exactly the wrapped value
        y_cand = {1'b0, y_q} + {5'd0, y_step};
        x_cand = dir_q ? ({1'b0, x_q} + {5'd0, x_step})
                       : ({1'b0, x_q} - {5'd0, x_step});
        cnt_inc = cnt_q + 6'd1;

        hit_top = y_cand[5];
`ifdef PROJ_WRAP_EN
        hit_side = 1'b0;
`else
        hit_side = x_cand[5];
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        maj_d   = maj_q;
        min_d   = min_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        steep_d = steep_q;
        dir_d   = dir_q;
        code_d  = code_q;

        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    x_d     = x_pos;
                    y_d     = 5'd0;
                    cnt_d   = 6'd0;
                    dir_d   = dir;
                    steep_d = launch_steep;
                    maj_d   = launch_maj;
                    min_d   = launch_min;
                    err_d   = {2'b00, launch_maj[4:1]};
                    code_d  = 2'b00;
                    state_d = S_FLY;
                end
            end
            S_FLY: begin
                if (tick) begin
                    cnt_d = cnt_inc;
                    if (hit_top) begin
                        code_d  = CODE_TOP;
                        state_d = S_DONE;
                    end else if (hit_side) begin
                        code_d  = CODE_SIDE;
                        state_d = S_DONE;
                    end else begin
                        x_d   = x_cand[4:0];
                        y_d   = y_cand[4:0];
                        err_d = minor_step ? (err_sum - {1'b0, maj_q}) : err_sum;
                        if (cnt_inc == STEP_LIMIT) begin
                            code_d  = CODE_LIMIT;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= 5'd0;
            y_q     <= 5'd0;
            maj_q   <= 5'd0;
            min_q   <= 5'd0;
            err_q   <= 6'd0;
            cnt_q   <= 6'd0;
            steep_q <= 1'b0;
            dir_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            maj_q   <= maj_d;
            min_q   <= min_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            steep_q <= steep_d;
            dir_q   <= dir_d;
            code_q  <= code_d;
        end
    end

    assign proj_x    = x_q;
    assign proj_y    = y_q;
    assign active    = (state_q == S_FLY);
    assign done      = (state_q == S_DONE);
    assign done_code = (state_q == S_DONE) ? code_q : 2'b00;

endmodule

// File: tb/tb_proj_step.sv
// Bench for proj_step: directed shots plus randomized shots. Every shot is
// checked cycle by cycle against a closed-form trajectory model.
module tb_proj_step;

    localparam int MAX_STEPS = 63;

    logic       clk = 1'b0;
    logic       reset, fire, tick, dir;
    logic [4:0] x_pos, run, rise;
    logic [4:0] proj_x, proj_y;
    logic       active, done;
    logic [1:0] done_code;

    int n_vec = 0;
    int n_err = 0;

    // Launch parameters of the shot currently being modelled
    int m_x0, m_mj, m_mn;
    bit m_steep, m_dir;

    proj_step #(.MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .reset(reset), .fire(fire), .tick(tick),
        .x_pos(x_pos), .run(run), .rise(rise), .dir(dir),
        .proj_x(proj_x), .proj_y(proj_y), .active(active),
        .done(done), .done_code(done_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // After k steps the major axis has moved k cells. The minor axis has moved
    // floor((major/2 + k*minor)/major) cells. code = 0 if step k is legal.
    function automatic void model_step(input int k, output int ex, output int ey,
                                       output int code);
        int maj_off, min_off, xoff, raw_x;
        maj_off = k;
        min_off = (m_mj / 2 + k * m_mn) / m_mj;
        xoff    = m_steep ? min_off : maj_off;
        ey      = m_steep ? maj_off : min_off;
        raw_x   = m_dir ? (m_x0 + xoff) : (m_x0 - xoff);
        ex      = ((raw_x % 32) + 32) % 32;
        code    = 0;
        if (ey >= 32) code = 1;
`ifndef PROJ_WRAP_EN
        else if (raw_x < 0 || raw_x > 31) code = 2;
`endif
        else if (k == MAX_STEPS) code = 3;
    endfunction

    // Launch one shot and follow it to termination. If stop_after > 0, return
    // while still in flight once that many steps have been committed.
    task automatic shot(input int x0, input int r, input int s, input bit d,
                        input int tick_pct, input int stop_after);
        int  cx, cy, k, ex, ey, code, ss;
        bit  t, fin;
        x_pos = 5'(x0); run = 5'(r); rise = 5'(s); dir = d;
        fire  = 1'b1; tick = 1'($urandom);
        @(posedge clk); #1;
        fire = 1'b0;
        ss      = (r == 0 && s == 0) ? 1 : s;
        m_steep = (ss >= r);
        m_mj    = m_steep ? ss : r;
        m_mn    = m_steep ? r : ss;
        m_x0    = x0;
        m_dir   = d;
        chk("launch_active", int'(active), 1);
        chk("launch_x", int'(proj_x), x0);
        chk("launch_y", int'(proj_y), 0);
        chk("launch_done", int'(done), 0);
        cx = x0; cy = 0; k = 0; fin = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            t     = ($urandom_range(99) < tick_pct);
            tick  = t;
            fire  = ($urandom_range(3) == 0);
            x_pos = 5'($urandom); run = 5'($urandom);
            rise  = 5'($urandom); dir = 1'($urandom);
            @(posedge clk); #1;
            if (t) begin
                k++;
                model_step(k, ex, ey, code);
                if (code == 3) begin
                    cx = ex; cy = ey;
                end
                if (code != 0) begin
                    fin = 1'b1;
                    chk("term_done", int'(done), 1);
                    chk("term_code", int'(done_code), code);
                    chk("term_active", int'(active), 0);
                    chk("term_x", int'(proj_x), cx);
                    chk("term_y", int'(proj_y), cy);
                end else begin
                    cx = ex; cy = ey;
                end
            end
            if (!fin) begin
                chk("fly_x", int'(proj_x), cx);
                chk("fly_y", int'(proj_y), cy);
                chk("fly_active", int'(active), 1);
                chk("fly_done", int'(done), 0);
                if (stop_after > 0 && k >= stop_after) return;
            end
        end
        if (!fin) begin
            chk("flight_timeout", 0, 1);
        end else begin
            fire = 1'b0; tick = 1'($urandom);
            @(posedge clk); #1;
            chk("idle_done", int'(done), 0);
            chk("idle_code", int'(done_code), 0);
            chk("idle_active", int'(active), 0);
            chk("idle_x", int'(proj_x), cx);
            chk("idle_y", int'(proj_y), cy);
        end
    endtask

    initial begin
        reset = 1'b0; fire = 1'b0; tick = 1'b0; dir = 1'b0;
        x_pos = 5'd0; run = 5'd0; rise = 5'd0;
        #2;
        chk("rst_x", int'(proj_x), 0);
        chk("rst_y", int'(proj_y), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_code", int'(done_code), 0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        // Directed shots
        shot(10, 2, 4, 1'b1, 100, 0);   // steep, top edge
        shot(3, 5, 0, 1'b0, 100, 0);    // shallow left, side edge or wrap
        shot(7, 0, 0, 1'b1, 70, 0);     // degenerate vertical shot
        shot(31, 1, 1, 1'b1, 100, 0);   // tie is steep, corner
        shot(0, 1, 1, 1'b0, 100, 0);    // corner leftward
        shot(16, 9, 9, 1'b1, 30, 0);    // sparse ticks

        // Reset mid-flight
        shot(12, 3, 7, 1'b0, 80, 5);
        reset = 1'b0;
        #1;
        chk("midrst_x", int'(proj_x), 0);
        chk("midrst_y", int'(proj_y), 0);
        chk("midrst_active", int'(active), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge clk); #1;
        chk("midrst_done2", int'(done), 0);
        chk("midrst_code2", int'(done_code), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        shot(12, 3, 7, 1'b0, 100, 0);

        // Randomized shots
        repeat (40) begin
            shot(int'($urandom_range(31)), int'($urandom_range(31)),
                 int'($urandom_range(31)), 1'($urandom),
                 50 + int'($urandom_range(50)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
